fpdiv_iter: RTL

//  Iterative fixed-point divider: c = (a << d) / b, one quotient bit per cycle (restoring).

---
 rtl/fpdiv_pkg.sv | 29 ++
 rtl/fpdiv_if.sv | 39 +++
 rtl/fpdiv_datapath.sv | 141 ++++++++++++++
 rtl/fpdiv_iter.sv | 100 ++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// ----------------------------------------------------------------------------
// fpdiv_pkg
// Shared types and sizing helpers for the iterative fixed-point divider.
//   - fpdiv_state_e      : control FSM states (IDLE, CALC, DONE)
//   - FPDIV_N / FPDIV_D  : default operand width and fractional bit count
//   - fpdiv_iters()      : number of restoring iterations (n + d)
//   - fpdiv_cnt_width()  : iteration counter width, $clog2(n + d + 1)
// ----------------------------------------------------------------------------
package fpdiv_pkg;

    localparam int FPDIV_N = 32;
    localparam int FPDIV_D = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fpdiv_state_e;

    // One quotient bit is produced per iteration over the full (n+d)-bit dividend.
    function automatic int fpdiv_iters(input int n, input int d);
        return n + d;
    endfunction

    function automatic int fpdiv_cnt_width(input int n, input int d);
        return $clog2(n + d + 1);
    endfunction

endpackage

// File: rtl/fpdiv_if.sv
// ----------------------------------------------------------------------------
// fpdiv_if
// val/rdy message interface of the fixed-point divider.
//   recv_val / recv_rdy / recv_msg[2n-1:0] : request  {a dividend, b divisor}
//   send_val / send_rdy / send_msg[n-1:0]  : response (quotient c)
// Modports:
//   master : requester side (drives requests, consumes results)
//   slave  : divider side
// ----------------------------------------------------------------------------
interface fpdiv_if #(
    parameter int n = 32
) ();

    logic             recv_val;
    logic             recv_rdy;
    logic [2*n-1:0]   recv_msg;
    logic             send_val;
    logic             send_rdy;
    logic [n-1:0]     send_msg;

    modport master (
        output recv_val,
        output recv_msg,
        output send_rdy,
        input  recv_rdy,
        input  send_val,
        input  send_msg
    );

    modport slave (
        input  recv_val,
        input  recv_msg,
        input  send_rdy,
        output recv_rdy,
        output send_val,
        output send_msg
    );

endinterface

// File: rtl/fpdiv_datapath.sv
// ----------------------------------------------------------------------------
// fpdiv_datapath
// Restoring-division datapath: dividend shift register (a << d), divisor,
// remainder (n+1 bits) and quotient (n+d bits), one quotient bit per step.
// Optional macro FPDIV_SIGNED_EN: operands are two's complement; magnitudes
// and the result sign are captured at load and the quotient is negated on
// the way out. Divide by zero saturates to max positive / min negative.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : latch a/b and clear remainder/quotient
//   step       : perform one restoring iteration
//   a, b       : dividend and divisor operands (n bits each)
//   cnt        : iteration counter owned by the controller
//   last_iter  : high while cnt addresses the final iteration
//   quot       : quotient result (n bits)
// ----------------------------------------------------------------------------
module fpdiv_datapath
    import fpdiv_pkg::*;
#(
    parameter int n = FPDIV_N,
    parameter int d = FPDIV_D
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load,
    input  logic                              step,
    input  logic [n-1:0]                      a,
    input  logic [n-1:0]                      b,
    input  logic [fpdiv_cnt_width(n, d)-1:0]  cnt,
    output logic                              last_iter,
    output logic [n-1:0]                      quot
);

    localparam int W     = fpdiv_iters(n, d);
    localparam int CNT_W = fpdiv_cnt_width(n, d);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    logic [W-1:0]  dvd_r;
    logic [n-1:0]  dvs_r;
    logic [n:0]    rem_r;
    logic [W-1:0]  quo_r;

    logic [n:0]    rs_s;
    logic [n:0]    rem_next_s;
    logic          qbit_s;
    logic [n-1:0]  a_load_s;
    logic [n-1:0]  b_load_s;
    logic          unused_bits_s;

`ifdef FPDIV_SIGNED_EN
    logic          sign_r;
    logic          a_neg_r;
    logic          b_zero_r;

    // Operand magnitudes; |-2^(n-1)| wraps to 2^(n-1), which is correct as unsigned.
    always_comb begin
        a_load_s = a;
        b_load_s = b;
        if (a[n-1]) begin
            a_load_s = -a;
        end else begin
            a_load_s = a;
        end
        if (b[n-1]) begin
            b_load_s = -b;
        end else begin
            b_load_s = b;
        end
    end

    // Sign bookkeeping captured together with the operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_r   <= 1'b0;
            a_neg_r  <= 1'b0;
            b_zero_r <= 1'b0;
        end else if (load) begin
            sign_r   <= a[n-1] ^ b[n-1];
            a_neg_r  <= a[n-1];
            b_zero_r <= (b == {n{1'b0}});
        end
    end

    // Signed result: saturate on divide by zero, otherwise apply the sign.
    always_comb begin
        quot = quo_r[n-1:0];
        if (b_zero_r) begin
            if (a_neg_r) begin
                quot = {1'b1, {(n-1){1'b0}}};
            end else begin
                quot = {1'b0, {(n-1){1'b1}}};
            end
        end else if (sign_r) begin
            quot = -quo_r[n-1:0];
        end else begin
            quot = quo_r[n-1:0];
        end
    end
`else
    assign a_load_s = a;
    assign b_load_s = b;
    assign quot     = quo_r[n-1:0];
`endif

    // One restoring step: shift in next dividend bit, subtract divisor if it fits.
    always_comb begin
        rs_s = {rem_r[n-1:0], dvd_r[W-1]};
        if (rs_s >= {1'b0, dvs_r}) begin
            rem_next_s = rs_s - {1'b0, dvs_r};
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = rs_s;
            qbit_s     = 1'b0;
        end
    end

    // Datapath registers: load operands, then iterate under controller strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_r <= {W{1'b0}};
            dvs_r <= {n{1'b0}};
            rem_r <= {(n+1){1'b0}};
            quo_r <= {W{1'b0}};
        end else if (load) begin
            dvd_r <= {a_load_s, {d{1'b0}}};
            dvs_r <= b_load_s;
            rem_r <= {(n+1){1'b0}};
            quo_r <= {W{1'b0}};
        end else if (step) begin
            dvd_r <= {dvd_r[W-2:0], 1'b0};
            rem_r <= rem_next_s;
            quo_r <= {quo_r[W-2:0], qbit_s};
        end
    end

    assign last_iter = (cnt == LAST_CNT);

    // Quotient bits above n wrap away; rem_r[n] is always zero after a step.
    assign unused_bits_s = ^{quo_r[W-1:n], rem_r[n]};

endmodule

// File: rtl/fpdiv_iter.sv
// ----------------------------------------------------------------------------
// fpdiv_iter
// Iterative fixed-point divider, c = (a << d) / b, restoring algorithm with
// one quotient bit per cycle (n + d iterations). Qn.d format, truncating,
// quotient wraps to n bits, b == 0 gives all ones (unsigned build).
// Optional macro FPDIV_SIGNED_EN: two's complement operands (see datapath).
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset (aborts any operation)
//   io     : fpdiv_if.slave  -- recv_val/recv_rdy/recv_msg {a,b},
//                               send_val/send_rdy/send_msg c
// Control: IDLE -(recv_val)-> CALC -(final iteration)-> DONE -(send_rdy)-> IDLE
// ----------------------------------------------------------------------------
module fpdiv_iter
    import fpdiv_pkg::*;
#(
    parameter int n = FPDIV_N,
    parameter int d = FPDIV_D
) (
    input  logic    clk,
    input  logic    reset,
    fpdiv_if.slave  io
);

    localparam int CNT_W = fpdiv_cnt_width(n, d);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fpdiv_state_e      state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              recv_rdy_r;
    logic              send_val_r;
    logic              accept_s;
    logic              step_s;
    logic              last_iter_s;
    logic [n-1:0]      quot_s;

    assign accept_s = (state_r == IDLE) && io.recv_val;
    assign step_s   = (state_r == CALC);

    fpdiv_datapath #(
        .n (n),
        .d (d)
    ) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_s),
        .step      (step_s),
        .a         (io.recv_msg[2*n-1:n]),
        .b         (io.recv_msg[n-1:0]),
        .cnt       (cnt_r),
        .last_iter (last_iter_s),
        .quot      (quot_s)
    );

    // Control FSM, iteration counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            recv_rdy_r <= 1'b1;
            send_val_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (io.recv_val) begin
                        state_r    <= CALC;
                        cnt_r      <= {CNT_W{1'b0}};
                        recv_rdy_r <= 1'b0;
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (last_iter_s) begin
                        state_r    <= DONE;
                        send_val_r <= 1'b1;
                    end
                end
                DONE: begin
                    // recv_rdy stays low here, so no request is taken on the transfer cycle.
                    if (io.send_rdy) begin
                        state_r    <= IDLE;
                        send_val_r <= 1'b0;
                        recv_rdy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= {CNT_W{1'b0}};
                    recv_rdy_r <= 1'b1;
                    send_val_r <= 1'b0;
                end
            endcase
        end
    end

    assign io.recv_rdy = recv_rdy_r;
    assign io.send_val = send_val_r;
    assign io.send_msg = quot_s;

endmodule
